mem_miss_arbiter: RTL and testbench

// Shares the single memory-hierarchy port between I$ and D$ line-miss requests (per-thread

---
 rtl/mem_miss_arbiter_pkg.sv | 24 ++
 rtl/mem_miss_arbiter_if.sv | 40 ++++
 rtl/mem_miss_arbiter_slot.sv | 43 ++++
 rtl/mem_miss_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_miss_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_miss_arbiter_pkg.sv
// rtl/mem_miss_arbiter_pkg.sv - shared types and constants for the I$/D$ miss arbiter
package mem_miss_arbiter_pkg;

   localparam int DCACHE_LINE_WIDTH  = 64;
   localparam int THR_PER_CORE       = 2;
   localparam int THR_PER_CORE_WIDTH = 1;
   localparam int MEM_ARB_TIMEOUT    = 256;

   // Miss request as seen by memory; data carries the D$ writeback line.
   typedef struct packed {
      logic [31:0]                  addr;
      logic                         is_write;
      logic [DCACHE_LINE_WIDTH-1:0] data;
   } memory_request_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} arb_state_t;

   typedef enum logic {SRC_IC, SRC_DC} arb_src_t;

   function automatic arb_src_t other_src(input arb_src_t s);
      return (s == SRC_IC) ? SRC_DC : SRC_IC;
   endfunction

endpackage

// File: rtl/mem_miss_arbiter_if.sv
// rtl/mem_miss_arbiter_if.sv - cache miss port and memory port bundles
interface miss_port_if
   import mem_miss_arbiter_pkg::*;
#(
   parameter int LINE_W = DCACHE_LINE_WIDTH
);
   logic                          req_valid;
   memory_request_t               req_info;
   logic [THR_PER_CORE_WIDTH-1:0] req_thread_id;
   logic                          rsp_valid;
   logic [LINE_W-1:0]             rsp_data;
   logic [THR_PER_CORE_WIDTH-1:0] rsp_thread_id;
   logic                          rsp_bus_error;

   // master = cache side, slave = arbiter side
   modport master (output req_valid, req_info, req_thread_id,
                   input  rsp_valid, rsp_data, rsp_thread_id, rsp_bus_error);
   modport slave  (input  req_valid, req_info, req_thread_id,
                   output rsp_valid, rsp_data, rsp_thread_id, rsp_bus_error);
endinterface

interface mem_port_if
   import mem_miss_arbiter_pkg::*;
#(
   parameter int LINE_W = DCACHE_LINE_WIDTH
);
   logic                          req_valid;
   logic                          req_ready;
   memory_request_t               req_info;
   logic [THR_PER_CORE_WIDTH-1:0] req_thread_id;
   logic                          rsp_valid;
   logic [LINE_W-1:0]             rsp_data;
   logic                          rsp_bus_error;

   // master = arbiter side, slave = memory side
   modport master (output req_valid, req_info, req_thread_id,
                   input  req_ready, rsp_valid, rsp_data, rsp_bus_error);
   modport slave  (input  req_valid, req_info, req_thread_id,
                   output req_ready, rsp_valid, rsp_data, rsp_bus_error);
endinterface

// File: rtl/mem_miss_arbiter_slot.sv
// rtl/mem_miss_arbiter_slot.sv - single-entry pending miss buffer with per-thread flush
module miss_req_slot
   import mem_miss_arbiter_pkg::*;
(
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          load,
   input  memory_request_t               load_info,
   input  logic [THR_PER_CORE_WIDTH-1:0] load_thread,
   input  logic [THR_PER_CORE-1:0]       flush_thread,
   input  logic                          clear,
   output logic                          valid,
   output memory_request_t               info,
   output logic [THR_PER_CORE_WIDTH-1:0] thread
);
   logic load_ok;
   logic flush_hit;

   // A flush of the incoming thread beats the load in the same cycle.
   assign load_ok   = load && !flush_thread[load_thread];
   assign flush_hit = valid && flush_thread[thread];

   // Slot storage: load into an empty (or just-granted) slot, drop on grant or flush.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid  <= 1'b0;
         info   <= '0;
         thread <= '0;
      end else if (load_ok && (!valid || clear)) begin
         valid  <= 1'b1;
         info   <= load_info;
         thread <= load_thread;
      end else if (clear || flush_hit) begin
         valid  <= 1'b0;
      end
   end

   // A pulse into an occupied slot is lost; caches must not issue a second miss.
   always_ff @(posedge clock) begin
      if (!reset)
         assert (!(load && valid && !clear)) else $error("miss_req_slot: request dropped, slot full");
   end
endmodule

// File: rtl/mem_miss_arbiter.sv
// rtl/mem_miss_arbiter.sv - round-robin I$/D$ line-miss arbiter onto one memory port
module mem_miss_arbiter
   import mem_miss_arbiter_pkg::*;
#(
   parameter int LINE_W      = DCACHE_LINE_WIDTH,
   parameter int TIMEOUT_CYC = MEM_ARB_TIMEOUT
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [THR_PER_CORE-1:0] flush_thread,
   miss_port_if.slave              ic,
   miss_port_if.slave              dc,
   mem_port_if.master              mem
);
   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

   arb_state_t                    state, state_next;
   arb_src_t                      rr, owner, grant_src;
   logic                          grant, accept, finish, timeout_hit;
   logic                          discard, stale;
   logic [CNT_W-1:0]              count;
   logic                          ic_slot_valid, dc_slot_valid, ic_clear, dc_clear;
   memory_request_t               ic_slot_info, dc_slot_info, grant_info, req_info_q;
   logic [THR_PER_CORE_WIDTH-1:0] ic_slot_thread, dc_slot_thread, grant_thread, req_thread_q;
   logic                          rsp_fire, to_ic, to_dc, rsp_error;
   logic [LINE_W-1:0]             rsp_line;

   miss_req_slot u_ic_slot (
      .clock(clock), .reset(reset), .load(ic.req_valid), .load_info(ic.req_info),
      .load_thread(ic.req_thread_id), .flush_thread(flush_thread), .clear(ic_clear),
      .valid(ic_slot_valid), .info(ic_slot_info), .thread(ic_slot_thread)
   );

   miss_req_slot u_dc_slot (
      .clock(clock), .reset(reset), .load(dc.req_valid), .load_info(dc.req_info),
      .load_thread(dc.req_thread_id), .flush_thread(flush_thread), .clear(dc_clear),
      .valid(dc_slot_valid), .info(dc_slot_info), .thread(dc_slot_thread)
   );

   assign ic_clear     = grant && (grant_src == SRC_IC);
   assign dc_clear     = grant && (grant_src == SRC_DC);
   assign grant_info   = (grant_src == SRC_DC) ? dc_slot_info   : ic_slot_info;
   assign grant_thread = (grant_src == SRC_DC) ? dc_slot_thread : ic_slot_thread;

   assign mem.req_valid     = (state == ISSUE);
   assign mem.req_info      = req_info_q;
   assign mem.req_thread_id = req_thread_q;

   // Timeouts return an all-zero line flagged as a bus error.
   assign rsp_fire  = (finish || timeout_hit) && !discard;
   assign to_ic     = rsp_fire && (owner == SRC_IC);
   assign to_dc     = rsp_fire && (owner == SRC_DC);
   assign rsp_line  = finish ? mem.rsp_data : '0;
   assign rsp_error = finish ? mem.rsp_bus_error : 1'b1;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_next  = state;
      grant       = 1'b0;
      grant_src   = SRC_IC;
      accept      = 1'b0;
      finish      = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (ic_slot_valid || dc_slot_valid) begin
               grant      = 1'b1;
               grant_src  = (ic_slot_valid && dc_slot_valid) ? rr :
                            (dc_slot_valid ? SRC_DC : SRC_IC);
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (mem.req_ready) begin
               accept     = 1'b1;
               state_next = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (mem.rsp_valid) begin
               finish     = 1'b1;
               state_next = IDLE;
            end else if (count == CNT_LAST) begin
               timeout_hit = 1'b1;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Grant bookkeeping: request registers, owner, rr pointer, discard, timeout and stale tracking.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr           <= SRC_IC;
         owner        <= SRC_IC;
         req_info_q   <= '0;
         req_thread_q <= '0;
         discard      <= 1'b0;
         stale        <= 1'b0;
         count        <= '0;
      end else begin
         if (grant) begin
            owner        <= grant_src;
            req_info_q   <= grant_info;
            req_thread_q <= grant_thread;
            discard      <= flush_thread[grant_thread];
            if (ic_slot_valid && dc_slot_valid)
               rr <= other_src(grant_src);
         end else if (state != IDLE && flush_thread[req_thread_q]) begin
            discard <= 1'b1;
         end
         if (accept)
            count <= '0;
         else if (state == WAIT_RSP && count != CNT_MAX)
            count <= count + 1'b1;
         if (timeout_hit)
            stale <= 1'b1;
         else if (mem.rsp_valid && state != WAIT_RSP)
            stale <= 1'b0;
      end
   end

   // Response demux: one-cycle pulse to the owning cache.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ic.rsp_valid     <= 1'b0;
         ic.rsp_data      <= '0;
         ic.rsp_thread_id <= '0;
         ic.rsp_bus_error <= 1'b0;
         dc.rsp_valid     <= 1'b0;
         dc.rsp_data      <= '0;
         dc.rsp_thread_id <= '0;
         dc.rsp_bus_error <= 1'b0;
      end else begin
         ic.rsp_valid     <= to_ic;
         ic.rsp_data      <= to_ic ? rsp_line : '0;
         ic.rsp_thread_id <= to_ic ? req_thread_q : '0;
         ic.rsp_bus_error <= to_ic && rsp_error;
         dc.rsp_valid     <= to_dc;
         dc.rsp_data      <= to_dc ? rsp_line : '0;
         dc.rsp_thread_id <= to_dc ? req_thread_q : '0;
         dc.rsp_bus_error <= to_dc && rsp_error;
      end
   end

   // A response with nothing outstanding is only legal when it absorbs a timed-out txn.
   always_ff @(posedge clock) begin
      if (!reset && state == IDLE && mem.rsp_valid)
         assert (stale) else $error("mem_miss_arbiter: unexpected memory response while idle");
   end
endmodule

// File: tb/tb_mem_miss_arbiter.sv
// tb/tb_mem_miss_arbiter.sv - directed scoreboard bench for mem_miss_arbiter
module tb_mem_miss_arbiter;
   import mem_miss_arbiter_pkg::*;

   localparam int LW = DCACHE_LINE_WIDTH;

   typedef struct {
      arb_src_t        src;
      logic            thr;
      logic [LW-1:0]   data;
      logic            err;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [THR_PER_CORE-1:0] flush = '0;
   int                      n_checks = 0;
   int                      n_fail   = 0;
   exp_t                    sb[$];

   miss_port_if #(.LINE_W(LW)) ic_bus ();
   miss_port_if #(.LINE_W(LW)) dc_bus ();
   mem_port_if  #(.LINE_W(LW)) mem_bus ();

   mem_miss_arbiter #(.LINE_W(LW), .TIMEOUT_CYC(16)) dut (
      .clock(clk), .reset(rst), .flush_thread(flush),
      .ic(ic_bus), .dc(dc_bus), .mem(mem_bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input arb_src_t src, input logic [31:0] addr, input logic thr);
      memory_request_t r;
      r.addr     = addr;
      r.is_write = (src == SRC_DC);
      r.data     = {32'hC0DE0000, addr};
      if (src == SRC_IC) begin
         ic_bus.req_valid = 1'b1; ic_bus.req_info = r; ic_bus.req_thread_id = thr;
      end else begin
         dc_bus.req_valid = 1'b1; dc_bus.req_info = r; dc_bus.req_thread_id = thr;
      end
   endtask

   task automatic pulse(input arb_src_t src, input logic [31:0] addr, input logic thr);
      set_req(src, addr, thr);
      tick();
      ic_bus.req_valid = 1'b0;
      dc_bus.req_valid = 1'b0;
   endtask

   task automatic wait_req(input string tag, input logic [31:0] addr, input logic thr);
      int n = 0;
      while (mem_bus.req_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, mem_bus.req_valid, 1'b1);
      check({tag, "_addr"}, mem_bus.req_info.addr, addr);
      check({tag, "_thr"}, mem_bus.req_thread_id, thr);
   endtask

   // Memory returns a line; the expected cache pulse is queued unless the txn is discarded.
   task automatic respond(input arb_src_t src, input logic thr, input logic [LW-1:0] data,
                          input logic err, input logic discard);
      exp_t e;
      e.src = src; e.thr = thr; e.data = data; e.err = err;
      if (!discard) sb.push_back(e);
      mem_bus.rsp_valid     = 1'b1;
      mem_bus.rsp_data      = data;
      mem_bus.rsp_bus_error = err;
      tick();
      mem_bus.rsp_valid     = 1'b0;
      mem_bus.rsp_bus_error = 1'b0;
   endtask

   task automatic score(input arb_src_t src, input logic thr, input logic [LW-1:0] data, input logic err);
      exp_t e;
      if (sb.size() == 0) begin
         check(src == SRC_IC ? "sb_unexpected_ic_rsp" : "sb_unexpected_dc_rsp", 1'b1, 1'b0);
      end else begin
         e = sb.pop_front();
         check("sb_src", src, e.src);
         check("sb_thr", thr, e.thr);
         check("sb_data", data, e.data);
         check("sb_err", err, e.err);
      end
   endtask

   // Response monitor: every cache pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (ic_bus.rsp_valid === 1'b1)
            score(SRC_IC, ic_bus.rsp_thread_id, ic_bus.rsp_data, ic_bus.rsp_bus_error);
         if (dc_bus.rsp_valid === 1'b1)
            score(SRC_DC, dc_bus.rsp_thread_id, dc_bus.rsp_data, dc_bus.rsp_bus_error);
      end
   end

   initial begin
      ic_bus.req_valid = 1'b0; ic_bus.req_info = '0; ic_bus.req_thread_id = '0;
      dc_bus.req_valid = 1'b0; dc_bus.req_info = '0; dc_bus.req_thread_id = '0;
      mem_bus.req_ready = 1'b1; mem_bus.rsp_valid = 1'b0;
      mem_bus.rsp_data = '0; mem_bus.rsp_bus_error = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_mem_valid", mem_bus.req_valid, 1'b0);
      check("rst_mem_info", mem_bus.req_info, '0);
      check("rst_ic_rsp", ic_bus.rsp_valid, 1'b0);
      check("rst_dc_rsp", dc_bus.rsp_valid, 1'b0);
      rst = 1'b0;
      tick();

      // 1: solo D$ miss, latency req N -> mem N+2 for one cycle, rsp M -> dc rsp M+1
      pulse(SRC_DC, 32'h1000, 1'b0);
      check("t1_n1_idle", mem_bus.req_valid, 1'b0);
      tick();
      check("t1_n2_valid", mem_bus.req_valid, 1'b1);
      check("t1_n2_addr", mem_bus.req_info.addr, 32'h1000);
      check("t1_n2_thr", mem_bus.req_thread_id, 1'b0);
      tick();
      check("t1_n3_drop", mem_bus.req_valid, 1'b0);
      repeat (5) tick();
      respond(SRC_DC, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1'b0);
      check("t1_dc_rsp", dc_bus.rsp_valid, 1'b1);
      check("t1_dc_data", dc_bus.rsp_data, 64'hA5A5_A5A5_A5A5_A5A5);
      check("t1_ic_quiet", ic_bus.rsp_valid, 1'b0);
      tick();
      check("t1_dc_pulse_end", dc_bus.rsp_valid, 1'b0);

      // 2: contention, rr starts at I$, then alternates
      set_req(SRC_IC, 32'h2000, 1'b0);
      set_req(SRC_DC, 32'h3000, 1'b1);
      tick();
      ic_bus.req_valid = 1'b0; dc_bus.req_valid = 1'b0;
      wait_req("t2_first_ic", 32'h2000, 1'b0);
      tick();
      respond(SRC_IC, 1'b0, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
      wait_req("t2_then_dc", 32'h3000, 1'b1);
      tick();
      respond(SRC_DC, 1'b1, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
      set_req(SRC_IC, 32'h2100, 1'b1);
      set_req(SRC_DC, 32'h3100, 1'b0);
      tick();
      ic_bus.req_valid = 1'b0; dc_bus.req_valid = 1'b0;
      wait_req("t2_second_dc", 32'h3100, 1'b0);
      tick();
      respond(SRC_DC, 1'b0, 64'h0000_0000_DEAD_0001, 1'b0, 1'b0);
      wait_req("t2_second_ic", 32'h2100, 1'b1);
      tick();
      respond(SRC_IC, 1'b1, 64'h0000_0000_DEAD_0002, 1'b0, 1'b0);

      // 3: backpressure holds the request stable
      mem_bus.req_ready = 1'b0;
      pulse(SRC_IC, 32'h4000, 1'b0);
      wait_req("t3_req", 32'h4000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_hold_valid", mem_bus.req_valid, 1'b1);
         check("t3_hold_addr", mem_bus.req_info.addr, 32'h4000);
      end
      mem_bus.req_ready = 1'b1;
      tick();
      check("t3_accepted", mem_bus.req_valid, 1'b0);
      respond(SRC_IC, 1'b0, 64'h4444_0000_4444_0000, 1'b0, 1'b0);

      // 4: flush thread 1 while its D$ txn is in flight and an I$ thr1 miss is pending
      pulse(SRC_DC, 32'h5000, 1'b1);
      wait_req("t4_dc", 32'h5000, 1'b1);
      tick();
      pulse(SRC_IC, 32'h6000, 1'b1);
      flush = 2'b10;
      tick();
      flush = 2'b00;
      pulse(SRC_IC, 32'h7000, 1'b0);
      respond(SRC_DC, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b1);
      check("t4_dc_discard", dc_bus.rsp_valid, 1'b0);
      check("t4_ic_quiet", ic_bus.rsp_valid, 1'b0);
      wait_req("t4_ic_thr0", 32'h7000, 1'b0);
      tick();
      respond(SRC_IC, 1'b0, 64'h7777_7777_0000_0000, 1'b0, 1'b0);

      // 5: timeout after 16 WAIT_RSP cycles, late response absorbed, next txn normal
      pulse(SRC_DC, 32'h8000, 1'b0);
      wait_req("t5_dc", 32'h8000, 1'b0);
      begin
         exp_t e;
         e.src = SRC_DC; e.thr = 1'b0; e.data = '0; e.err = 1'b1;
         sb.push_back(e);
      end
      for (int k = 1; k <= 16; k++) begin
         tick();
         check("t5_no_early_rsp", dc_bus.rsp_valid, 1'b0);
      end
      tick();
      check("t5_timeout_valid", dc_bus.rsp_valid, 1'b1);
      check("t5_timeout_err", dc_bus.rsp_bus_error, 1'b1);
      repeat (3) tick();
      respond(SRC_DC, 1'b0, 64'hFEED_FEED_FEED_FEED, 1'b0, 1'b1);
      check("t5_late_dropped", dc_bus.rsp_valid, 1'b0);
      pulse(SRC_IC, 32'h9000, 1'b1);
      wait_req("t5_ic", 32'h9000, 1'b1);
      tick();
      respond(SRC_IC, 1'b1, 64'h9999_0000_9999_0000, 1'b0, 1'b0);

      // 6: memory bus error, then async reset in ISSUE
      pulse(SRC_IC, 32'hA000, 1'b0);
      wait_req("t6_ic", 32'hA000, 1'b0);
      tick();
      respond(SRC_IC, 1'b0, 64'h0000_DEAD_0000_DEAD, 1'b1, 1'b0);
      check("t6_ic_err", ic_bus.rsp_bus_error, 1'b1);
      mem_bus.req_ready = 1'b0;
      pulse(SRC_DC, 32'hB000, 1'b1);
      wait_req("t6_issue", 32'hB000, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_valid", mem_bus.req_valid, 1'b0);
      check("t6_rst_info", mem_bus.req_info, '0);
      check("t6_rst_thr", mem_bus.req_thread_id, 1'b0);
      tick();
      rst = 1'b0;
      mem_bus.req_ready = 1'b1;
      repeat (3) tick();
      check("t6_lost_after_rst", mem_bus.req_valid, 1'b0);
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
